// File: rtl/mod4591_sum6_reduce_pkg.sv
// Shared mod-4591 constants and stage types for the partial-residue reduction datapath.
package mod4591_sum6_reduce_pkg;

  localparam int unsigned Q = 4591;
  localparam logic [14:0] Q_X3 = 15'd13773;
  localparam logic [12:0] Q_HALF = 13'd2295;
  localparam logic [12:0] Q_13 = 13'd4591;

  // Fold thresholds k*Q, k = 1..5; together they cover the full 2165..25230 range of d.
  localparam logic [14:0] THRESH_1 = 15'd4591;
  localparam logic [14:0] THRESH_2 = 15'd9182;
  localparam logic [14:0] THRESH_3 = 15'd13773;
  localparam logic [14:0] THRESH_4 = 15'd18364;
  localparam logic [14:0] THRESH_5 = 15'd22955;

  typedef struct packed {
    logic [13:0] sp;
    logic [13:0] sn;
    logic        v;
  } stage1_t;

  typedef struct packed {
    logic [14:0] d;
    logic        v;
  } stage2_t;

endpackage

// File: rtl/mod4591_sum6_reduce_if.sv
// Bus bundle for the six-term mod-4591 reduction block.
// Handshake: valid-only stream. in_valid marks a live input set on each en=1 edge,
// out_valid marks a live z_out; there is no ready, the consumer must keep up.
interface mod4591_sum6_reduce_if;
  logic        en;
  logic        in_valid;
  logic [11:0] p0;
  logic [11:0] p1;
  logic [11:0] p2;
  logic [11:0] n0;
  logic [11:0] n1;
  logic [11:0] n2;
  logic [12:0] z_out;
  logic        out_valid;

  modport master (
    output en, in_valid, p0, p1, p2, n0, n1, n2,
    input  z_out, out_valid
  );

  modport slave (
    input  en, in_valid, p0, p1, p2, n0, n1, n2,
    output z_out, out_valid
  );
endinterface

// File: rtl/mod4591_fold15.sv
// One-stage fold of a 15-bit value (< 6*Q) into a mod-4591 residue using parallel
// threshold compares; optional centered (signed) output.
module mod4591_fold15
  import mod4591_sum6_reduce_pkg::*;
#(
  parameter bit CENTERED = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        in_valid,
  input  logic [14:0] d,
  output logic [12:0] z,
  output logic        out_valid
);

  logic [4:0]  ge;
  logic [2:0]  k;
  logic [14:0] sub;
  logic [14:0] red;
  logic [12:0] z_next;

  always_comb begin
    ge[0] = (d >= THRESH_1);
    ge[1] = (d >= THRESH_2);
    ge[2] = (d >= THRESH_3);
    ge[3] = (d >= THRESH_4);
    ge[4] = (d >= THRESH_5);
    k = 3'(ge[0]) + 3'(ge[1]) + 3'(ge[2]) + 3'(ge[3]) + 3'(ge[4]);
    case (k)
      3'd1:    sub = THRESH_1;
      3'd2:    sub = THRESH_2;
      3'd3:    sub = THRESH_3;
      3'd4:    sub = THRESH_4;
      3'd5:    sub = THRESH_5;
      default: sub = 15'd0;
    endcase
    red = d - sub;
    z_next = red[12:0];
    // 13-bit wraparound of (r - Q) is exactly its two's-complement encoding.
    if (CENTERED && (red[12:0] > Q_HALF)) begin
      z_next = red[12:0] - Q_13;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      z         <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      z         <= z_next;
      out_valid <= in_valid;
    end
  end

endmodule

// File: rtl/mod4591_sum6_reduce.sv
// Three-stage reduction of p0+p1+p2-n0-n1-n2 modulo 4591; fed directly by the
// registered outputs of the 33-bit partial-residue splitter.
module mod4591_sum6_reduce
  import mod4591_sum6_reduce_pkg::*;
#(
  parameter bit CENTERED = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  mod4591_sum6_reduce_if.slave       bus
);

  stage1_t s1;
  stage2_t s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
    end else if (bus.en) begin
      s1.sp <= {2'b00, bus.p0} + {2'b00, bus.p1} + {2'b00, bus.p2};
      s1.sn <= {2'b00, bus.n0} + {2'b00, bus.n1} + {2'b00, bus.n2};
      s1.v  <= bus.in_valid;
    end
  end

  // Adding 3Q keeps d non-negative for every legal input (worst case sn - sp = 11608).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2 <= '0;
    end else if (bus.en) begin
      s2.d <= {1'b0, s1.sp} - {1'b0, s1.sn} + Q_X3;
      s2.v <= s1.v;
    end
  end

  mod4591_fold15 #(
    .CENTERED (CENTERED)
  ) u_fold (
    .clk       (clk),
    .rst       (rst),
    .en        (bus.en),
    .in_valid  (s2.v),
    .d         (s2.d),
    .z         (bus.z_out),
    .out_valid (bus.out_valid)
  );

endmodule

// File: tb/tb_mod4591_sum6_reduce.sv
// Scoreboard bench for mod4591_sum6_reduce, canonical and centered builds side by side.
module tb_mod4591_sum6_reduce;

  logic clk;
  logic rst_n;

  mod4591_sum6_reduce_if b0 ();
  mod4591_sum6_reduce_if b1 ();

  mod4591_sum6_reduce #(.CENTERED(1'b0)) dut0 (.clk(clk), .rst(rst_n), .bus(b0));
  mod4591_sum6_reduce #(.CENTERED(1'b1)) dut1 (.clk(clk), .rst(rst_n), .bus(b1));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [12:0] exp_q[$];
  logic [12:0] exp_c_q[$];
  int          lat_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          en_cnt = 0;
  logic        en_q = 1'b0;
  logic [12:0] last_z0 = '0;
  logic [12:0] last_z1 = '0;
  logic        last_v0 = 1'b0;
  logic        last_v1 = 1'b0;

  // Directed vectors: p0 p1 p2 n0 n1 n2 expected_canonical expected_centered
  localparam int NDV = 11;
  localparam int DV[NDV][8] = '{
    '{0,    0,    0,    0,    0,    0,    0,    0},
    '{4095, 4076, 3286, 0,    0,    0,    2275, 2275},
    '{0,    0,    0,    4054, 3981, 3573, 2165, 2165},
    '{4095, 0,    0,    0,    0,    0,    4095, -496},
    '{0,    0,    0,    4054, 3981, 1148, 4590, -1},
    '{0,    0,    0,    4054, 3981, 1147, 0,    0},
    '{4095, 4076, 1010, 0,    0,    0,    4590, -1},
    '{4095, 4076, 1011, 0,    0,    0,    0,    0},
    '{2295, 0,    0,    0,    0,    0,    2295, 2295},
    '{2296, 0,    0,    0,    0,    0,    2296, -2295},
    '{100,  7,    0,    50,   0,    1,    56,   56}
  };

  always @(posedge clk) begin
    en_q <= b0.en;
    if (b0.en) en_cnt <= en_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [12:0] ref_mod(input int sp, input int sn, input bit centered);
    int r;
    r = (sp - sn) % 4591;
    if (r < 0) r = r + 4591;
    if (centered && r > 2295) r = r - 4591;
    return 13'(r);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input int a0, input int a1, input int a2,
                            input int c0, input int c1, input int c2,
                            input logic v, input logic e);
    b0.p0 = 12'(a0); b0.p1 = 12'(a1); b0.p2 = 12'(a2);
    b0.n0 = 12'(c0); b0.n1 = 12'(c1); b0.n2 = 12'(c2);
    b0.in_valid = v; b0.en = e;
    b1.p0 = 12'(a0); b1.p1 = 12'(a1); b1.p2 = 12'(a2);
    b1.n0 = 12'(c0); b1.n1 = 12'(c1); b1.n2 = 12'(c2);
    b1.in_valid = v; b1.en = e;
  endtask

  task automatic send(input int a0, input int a1, input int a2,
                      input int c0, input int c1, input int c2,
                      input logic v, input logic e,
                      input logic [12:0] x0, input logic [12:0] x1);
    set_inputs(a0, a1, a2, c0, c1, c2, v, e);
    @(posedge clk);
    #1;
    if (v && e) begin
      exp_q.push_back(x0);
      exp_c_q.push_back(x1);
      lat_q.push_back(en_cnt);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(0, 0, 0, 0, 0, 0, 1'b0, 1'b1, '0, '0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid_agree", int'(b1.out_valid), int'(b0.out_valid));
      if (en_q) begin
        if (b0.out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            chk("z_canonical", int'(b0.z_out), int'(exp_q.pop_front()));
            chk("z_centered", int'($signed(b1.z_out)), int'($signed(exp_c_q.pop_front())));
            chk("latency", en_cnt - lat_q.pop_front(), 2);
          end
        end
      end else begin
        chk("hold_z0", int'(b0.z_out), int'(last_z0));
        chk("hold_z1", int'(b1.z_out), int'(last_z1));
        chk("hold_v0", int'(b0.out_valid), int'(last_v0));
        chk("hold_v1", int'(b1.out_valid), int'(last_v1));
      end
    end
    last_z0 = b0.z_out;
    last_z1 = b1.z_out;
    last_v0 = b0.out_valid;
    last_v1 = b1.out_valid;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid0", int'(b0.out_valid), 0);
    chk("reset_z0", int'(b0.z_out), 0);
    chk("reset_valid1", int'(b1.out_valid), 0);
    chk("reset_z1", int'(b1.z_out), 0);
    rst_n = 1'b1;
    idle(2);

    // Directed vectors, back to back.
    for (int i = 0; i < NDV; i++) begin
      send(DV[i][0], DV[i][1], DV[i][2], DV[i][3], DV[i][4], DV[i][5],
           1'b1, 1'b1, 13'(DV[i][6]), 13'(DV[i][7]));
    end
    idle(4);

    // Random legal stream with en toggling; en=0 cycles carry junk that must be ignored.
    begin
      int sent;
      sent = 0;
      while (sent < 16) begin
        int a0, a1, a2, c0, c1, c2;
        logic e;
        a0 = $urandom_range(0, 4095); a1 = $urandom_range(0, 4076); a2 = $urandom_range(0, 3286);
        c0 = $urandom_range(0, 4054); c1 = $urandom_range(0, 3981); c2 = $urandom_range(0, 3573);
        e = ($urandom_range(0, 3) != 0);
        send(a0, a1, a2, c0, c1, c2, 1'b1, e,
             ref_mod(a0 + a1 + a2, c0 + c1 + c2, 1'b0),
             ref_mod(a0 + a1 + a2, c0 + c1 + c2, 1'b1));
        if (e) sent++;
      end
    end
    idle(4);

    // Mid-flight reset: two sets in the pipe must vanish.
    send(4095, 0, 0, 0, 0, 0, 1'b1, 1'b1, 13'd4095, 13'(-496));
    send(1, 2, 3, 0, 0, 0, 1'b1, 1'b1, 13'd6, 13'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid0", int'(b0.out_valid), 0);
    chk("async_rst_valid1", int'(b1.out_valid), 0);
    exp_q.delete();
    exp_c_q.delete();
    lat_q.delete();
    set_inputs(0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(5);
    send(10, 0, 0, 20, 0, 0, 1'b1, 1'b1, 13'd4581, 13'(-10));
    idle(1);

    // Drain with a bounded wait.
    begin
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 20) begin
        idle(1);
        budget++;
      end
      chk("drain_empty", exp_q.size(), 0);
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mod4591_sum6_reduce.md
MOD4591_SUM6_REDUCE -- requirements
Module: mod4591_sum6_reduce

Interface
REQ-001 Parameter CENTERED, default 0: 0 gives canonical output [0,4590]; 1 gives signed output [-2295,2295].
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 en  input  1  pipeline advance; when 0, all stages and out_valid hold.
REQ-005 in_valid  input  1  p0..n2 carry a valid partial-residue set this cycle.
REQ-006 p0, p1, p2  input  12 each  positive partial residues; p0 0..4095, p1 0..4076, p2 0..3286.
REQ-007 n0, n1, n2  input  12 each  negative partial residues; n0 0..4054, n1 0..3981, n2 0..3573.
REQ-008 z_out  output  13  result ≡ p0+p1+p2-n0-n1-n2 (mod 4591); unsigned when CENTERED=0, two's complement when CENTERED=1.
REQ-009 out_valid  output  1  z_out holds the result of a valid input set.

Function
REQ-010 Stage 1 (when en=1): SHALL register sp = p0+p1+p2 (14 bit, max 11457), sn = n0+n1+n2 (14 bit, max 11608), and v1 = in_valid.
REQ-011 Stage 2 (when en=1): SHALL register d = sp - sn + 13773 (3*4591) as 15-bit unsigned, range 2165..25230, and v2 = v1.
REQ-012 Stage 3 (when en=1): SHALL compute k = count of thresholds {4591, 9182, 13773, 18364, 22955} that are ≤ d, and SHALL register z_out = d - k*4591 and out_valid = v2.
REQ-013 Stage 3 thresholds SHALL be compared in parallel; no iterative subtraction.
REQ-014 CENTERED=1: after REQ-012, z_out values > 2295 SHALL be replaced by value-4591, within the same stage.
REQ-015 Latency SHALL be exactly 3 en=1 cycles from input sampling to z_out/out_valid.
REQ-016 Throughput SHALL be one input set per en=1 cycle; no back-pressure output.
REQ-017 With en=0, every register SHALL hold; inputs are ignored that cycle.
REQ-018 Data registers SHALL update on every en=1 cycle regardless of valid; only out_valid qualifies z_out.
REQ-019 Inputs outside the ranges of REQ-006/007 are illegal; output undefined, no hang.

Reset
REQ-020 rst=0 SHALL asynchronously clear sp, sn, d, v1, v2, z_out, out_valid to 0.
REQ-021 Reset mid-operation SHALL drop all in-flight results; out_valid stays 0 until 3 en=1 cycles after the first valid input following rst release.
REQ-022 No state other than the pipeline registers SHALL exist.

Structure
REQ-023 Constants Q=4591, 3Q offset and the five thresholds SHALL live in the shared package with the other mod-4591 constants.
REQ-024 Stage 3 reduction SHALL be a sub-module mod4591_fold15 (15-bit in, 13-bit out, one register stage), reusable elsewhere in the NTT datapath.
REQ-025 The block SHALL connect directly to the registered p0..n2 outputs of the upstream 33-bit partial-residue splitter, with in_valid delayed one cycle to match it.

Verification
REQ-026 All inputs 0, in_valid=1 -> after 3 cycles z_out=0, out_valid=1.
REQ-027 p0=p1=p2 at max (4095,4076,3286), n*=0 -> z_out=2275 (both CENTERED settings).
REQ-028 n0=4054, n1=3981, n2=3573, p*=0 -> z_out=2165; p0=4095 only -> 4095 (CENTERED=0), -496 (CENTERED=1).
REQ-029 Back-to-back stream of 16 random legal sets with en toggled pseudo-randomly -> outputs match a reference model in order, no drops or duplicates, held during en=0.
REQ-030 Assert rst=0 with 2 sets in flight -> out_valid=0 immediately (asynchronous) and those results never appear.
REQ-031 Exhaustive sweep of d boundaries (d=4590, 4591, 22954, 22955) via chosen inputs -> z_out = d mod 4591 exactly.
